// File: rtl/ysyx_22050019_pkg.sv
// Shared definitions for the ysyx_22050019 fetch front end: reset PC, ebreak, bus codes, IFU states.
package ysyx_22050019_pkg;

    localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;
    localparam logic [31:0] EBREAK       = 32'h0010_0073;
    localparam logic [1:0]  RESP_OKAY    = 2'b00;

    typedef enum logic [1:0] {
        IFU_IDLE = 2'd0,
        IFU_ADDR = 2'd1,
        IFU_DATA = 2'd2,
        IFU_HOLD = 2'd3
    } ifu_state_e;

    // Pick the 32-bit instruction out of the fetched doubleword using pc[2].
    function automatic logic [31:0] lane_sel(input logic upper, input logic [63:0] dword);
        return upper ? dword[63:32] : dword[31:0];
    endfunction

endpackage

// File: rtl/ysyx_22050019_ifu.sv
// Instruction fetch unit: holds the PC, fetches one instruction per read transaction and
// hands it to decode over a valid/ready handshake; decode's jump result picks the next PC.
module ysyx_22050019_ifu
    import ysyx_22050019_pkg::*;
#(
    parameter logic [63:0] RESET_PC = IFU_RESET_PC,
    parameter int unsigned BUS_W    = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             ar_valid,
    input  logic             ar_ready,
    output logic [63:0]      ar_addr,
    input  logic             r_valid,
    output logic             r_ready,
    input  logic [BUS_W-1:0] r_data,
    input  logic [1:0]       r_resp,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [31:0]      inst_o,
    output logic [63:0]      inst_addr_pc,
    input  logic             redirect_en,
    input  logic [63:0]      redirect_pc,
    output logic             fetch_err,
    output logic [63:0]      fetch_cnt
);

    ifu_state_e  state_q;
    logic [63:0] pc_q;
    logic        pc_misaligned;

    assign pc_misaligned = (pc_q[1:0] != 2'b00);

    // A misaligned PC never reaches the bus; ADDR turns it into an ebreak directly.
    assign ar_valid     = (state_q == IFU_ADDR) && !pc_misaligned;
    assign r_ready      = (state_q == IFU_DATA);
    assign ar_addr      = {pc_q[63:3], 3'b000};
    assign inst_addr_pc = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IFU_IDLE;
            pc_q       <= RESET_PC;
            inst_valid <= 1'b0;
            inst_o     <= 32'h0;
            fetch_err  <= 1'b0;
            fetch_cnt  <= 64'h0;
        end else begin
            case (state_q)
                IFU_IDLE: state_q <= IFU_ADDR;
                IFU_ADDR: begin
                    if (pc_misaligned) begin
                        inst_o     <= EBREAK;
                        fetch_err  <= 1'b1;
                        inst_valid <= 1'b1;
                        state_q    <= IFU_HOLD;
                    end else if (ar_ready) begin
                        state_q <= IFU_DATA;
                    end
                end
                IFU_DATA: begin
                    if (r_valid) begin
                        if (r_resp != RESP_OKAY) begin
                            inst_o    <= EBREAK;
                            fetch_err <= 1'b1;
                        end else begin
                            inst_o    <= lane_sel(pc_q[2], r_data);
                            fetch_err <= 1'b0;
                        end
                        inst_valid <= 1'b1;
                        state_q    <= IFU_HOLD;
                    end
                end
                IFU_HOLD: begin
                    // Redirect inputs are only meaningful on the accepting cycle.
                    if (inst_ready) begin
                        pc_q       <= redirect_en ? redirect_pc : pc_q + 64'd4;
                        fetch_cnt  <= fetch_cnt + 64'd1;
                        fetch_err  <= 1'b0;
                        inst_valid <= 1'b0;
                        state_q    <= IFU_ADDR;
                    end
                end
                default: state_q <= IFU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22050019_ifu.sv
// Bench for ysyx_22050019_ifu: directed and random fetches against a transaction-level model.
module tb_ysyx_22050019_ifu;

    localparam logic [63:0] RST_PC = 64'h8000_0000;
    localparam logic [63:0] EBRK   = 64'h0000_0000_0010_0073;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ar_valid, ar_ready;
    logic [63:0] ar_addr;
    logic        r_valid, r_ready;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_o;
    logic [63:0] inst_addr_pc;
    logic        redirect_en;
    logic [63:0] redirect_pc;
    logic        fetch_err;
    logic [63:0] fetch_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: architectural PC and number of accepted instructions.
    logic [63:0] m_pc;
    logic [63:0] m_cnt;

    ysyx_22050019_ifu dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ar_valid    (ar_valid),
        .ar_ready    (ar_ready),
        .ar_addr     (ar_addr),
        .r_valid     (r_valid),
        .r_ready     (r_ready),
        .r_data      (r_data),
        .r_resp      (r_resp),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_o      (inst_o),
        .inst_addr_pc(inst_addr_pc),
        .redirect_en (redirect_en),
        .redirect_pc (redirect_pc),
        .fetch_err   (fetch_err),
        .fetch_cnt   (fetch_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Redirect inputs outside the accepting cycle must be ignored, so keep them noisy.
    task automatic junk_redirect();
        redirect_en = 1'($urandom_range(0, 1));
        redirect_pc = {$urandom, $urandom};
    endtask

    task automatic fetch_one(input int ar_wait, input int r_wait, input int hold_wait,
                             input logic [1:0] resp, input logic redir,
                             input logic [63:0] rpc, input logic [63:0] data);
        logic [63:0] exp_inst;
        logic [63:0] exp_addr;
        logic        exp_err;
        exp_addr = {m_pc[63:3], 3'b000};
        if (m_pc[1:0] != 2'b00 || resp != 2'b00) begin
            exp_inst = EBRK;
            exp_err  = 1'b1;
        end else begin
            exp_inst = m_pc[2] ? {32'h0, data[63:32]} : {32'h0, data[31:0]};
            exp_err  = 1'b0;
        end
        if (m_pc[1:0] == 2'b00) begin
            for (int i = 0; i < ar_wait; i++) begin
                ar_ready = 1'b0;
                junk_redirect();
                check("ar_valid_wait", 64'(ar_valid), 64'd1);
                check("ar_addr_wait", ar_addr, exp_addr);
                check("r_ready_in_addr", 64'(r_ready), 64'd0);
                @(negedge clk);
            end
            ar_ready = 1'b1;
            check("ar_valid", 64'(ar_valid), 64'd1);
            check("ar_addr", ar_addr, exp_addr);
            @(negedge clk);
            ar_ready = 1'b0;
            for (int i = 0; i < r_wait; i++) begin
                r_valid = 1'b0;
                r_data  = {$urandom, $urandom};
                junk_redirect();
                check("r_ready_wait", 64'(r_ready), 64'd1);
                check("no_second_ar", 64'(ar_valid), 64'd0);
                check("inst_valid_early", 64'(inst_valid), 64'd0);
                @(negedge clk);
            end
            r_valid = 1'b1;
            r_data  = data;
            r_resp  = resp;
            check("r_ready", 64'(r_ready), 64'd1);
            @(negedge clk);
            r_valid = 1'b0;
            r_data  = {$urandom, $urandom};
            r_resp  = 2'($urandom);
        end else begin
            check("misaligned_no_ar", 64'(ar_valid), 64'd0);
            @(negedge clk);
        end
        for (int i = 0; i <= hold_wait; i++) begin
            if (i == hold_wait) begin
                inst_ready  = 1'b1;
                redirect_en = redir;
                redirect_pc = rpc;
            end else begin
                inst_ready = 1'b0;
                junk_redirect();
            end
            check("inst_valid", 64'(inst_valid), 64'd1);
            check("inst_o", 64'(inst_o), exp_inst);
            check("inst_addr_pc_hold", inst_addr_pc, m_pc);
            check("fetch_err", 64'(fetch_err), 64'(exp_err));
            check("no_ar_in_hold", 64'(ar_valid), 64'd0);
            @(negedge clk);
        end
        inst_ready = 1'b0;
        junk_redirect();
        m_cnt = m_cnt + 64'd1;
        m_pc  = redir ? rpc : m_pc + 64'd4;
        check("inst_valid_clr", 64'(inst_valid), 64'd0);
        check("fetch_err_clr", 64'(fetch_err), 64'd0);
        check("next_pc", inst_addr_pc, m_pc);
        check("next_ar_addr", ar_addr, {m_pc[63:3], 3'b000});
        check("fetch_cnt", fetch_cnt, m_cnt);
    endtask

    initial begin
        logic [63:0] tgt;
        rst_n       = 1'b0;
        ar_ready    = 1'b0;
        r_valid     = 1'b0;
        r_data      = 64'h0;
        r_resp      = 2'b00;
        inst_ready  = 1'b0;
        redirect_en = 1'b0;
        redirect_pc = 64'h0;
        m_pc        = RST_PC;
        m_cnt       = 64'h0;
        repeat (2) @(negedge clk);
        check("rst_ar_valid", 64'(ar_valid), 64'd0);
        check("rst_r_ready", 64'(r_ready), 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst_o", 64'(inst_o), 64'd0);
        check("rst_fetch_err", 64'(fetch_err), 64'd0);
        check("rst_fetch_cnt", fetch_cnt, 64'd0);
        check("rst_pc", inst_addr_pc, RST_PC);
        rst_n = 1'b1;
        check("idle_no_ar", 64'(ar_valid), 64'd0);
        @(negedge clk);

        // Back-to-back sequential fetches from one doubleword.
        fetch_one(0, 0, 0, 2'b00, 1'b0, 64'h0, 64'h0000_0093_0000_0013);
        fetch_one(0, 0, 0, 2'b00, 1'b0, 64'h0, 64'h0000_0093_0000_0013);
        check("cnt_after_two", fetch_cnt, 64'd2);
        // Taken jump, then bus wait states, then decode stall.
        fetch_one(0, 0, 0, 2'b00, 1'b1, 64'h8000_0100, {$urandom, $urandom});
        check("redirect_pc", inst_addr_pc, 64'h8000_0100);
        fetch_one(5, 3, 0, 2'b00, 1'b0, 64'h0, {$urandom, $urandom});
        fetch_one(0, 0, 4, 2'b00, 1'b0, 64'h0, {$urandom, $urandom});
        // Bus error, then misaligned target, then back to an aligned PC.
        fetch_one(1, 1, 1, 2'b10, 1'b1, 64'h8000_0102, {$urandom, $urandom});
        fetch_one(0, 0, 2, 2'b00, 1'b1, 64'h8000_0200, {$urandom, $urandom});
        // PC wrap across 2^64.
        fetch_one(0, 0, 0, 2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, {$urandom, $urandom});
        fetch_one(0, 0, 0, 2'b00, 1'b0, 64'h0, {$urandom, $urandom});
        check("pc_wrap", inst_addr_pc, 64'h0);

        for (int n = 0; n < 40; n++) begin
            tgt = 64'h8000_0000 + 64'($urandom_range(0, 255) * 4);
            if ($urandom_range(0, 7) == 0) tgt = tgt + 64'd2;
            fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)),
                      ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                      1'($urandom_range(0, 1)), tgt, {$urandom, $urandom});
        end
        if (m_pc[1:0] != 2'b00)
            fetch_one(0, 0, 0, 2'b00, 1'b1, RST_PC, 64'h0);

        // Reset in the middle of a data phase.
        ar_ready = 1'b1;
        @(negedge clk);
        ar_ready = 1'b0;
        check("mid_data_r_ready", 64'(r_ready), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_ar_valid", 64'(ar_valid), 64'd0);
        check("async_r_ready", 64'(r_ready), 64'd0);
        check("async_inst_valid", 64'(inst_valid), 64'd0);
        check("async_inst_o", 64'(inst_o), 64'd0);
        check("async_fetch_err", 64'(fetch_err), 64'd0);
        check("async_fetch_cnt", fetch_cnt, 64'd0);
        check("async_pc", inst_addr_pc, RST_PC);
        r_valid = 1'b1;
        r_data  = {$urandom, $urandom};
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("stray_r_ready", 64'(r_ready), 64'd0);
            check("stray_inst_valid", 64'(inst_valid), 64'd0);
            check("restart_ar_addr", ar_addr, RST_PC);
            @(negedge clk);
        end
        r_valid = 1'b0;
        m_pc    = RST_PC;
        m_cnt   = 64'h0;
        fetch_one(0, 0, 0, 2'b00, 1'b0, 64'h0, {$urandom, $urandom});
        check("cnt_after_reset", fetch_cnt, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
